// File: rtl/isu_sc_arbiter.sv
// rtl/isu_sc_arbiter.sv - round-robin ISU request arbiter with write-back beat split
//
// Shares the single sram_controller ISU request port among NCH requester
// channels. A one-entry output slot holds the granted request; whole-line
// WRITE_BACK requests are issued as two beats (offset 0, then offset 1) and
// the requester is acknowledged only when the final beat loads.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   per-channel request handshake (ready one-hot or zero)
//   req_opcode_i              per-channel opcode (3 bits each)
//   req_set_way_offset_i      per-channel {set_way[5:0], offset} (7 bits each)
//   req_all_offset_i          per-channel write-back-both-offsets flag
//   req_wbuffer_id_i          per-channel write-buffer id (8 bits each)
//   req_rob_num_i             per-channel xbar ROB number (3 bits each)
//   isu_sc_valid_o/ready_i    slot handshake toward sram_controller
//   isu_sc_channel_id_o       granted channel of the slot
//   isu_sc_opcode_o, isu_sc_set_way_offset_o, isu_sc_wbuffer_id_o,
//   isu_sc_xbar_rob_num_o     slot payload
//   isu_sc_last_o             slot holds the final beat of its request
module isu_sc_arbiter #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH-1:0]    req_valid_i,
  output logic [NCH-1:0]    req_ready_o,
  input  logic [3*NCH-1:0]  req_opcode_i,
  input  logic [7*NCH-1:0]  req_set_way_offset_i,
  input  logic [NCH-1:0]    req_all_offset_i,
  input  logic [8*NCH-1:0]  req_wbuffer_id_i,
  input  logic [3*NCH-1:0]  req_rob_num_i,
  output logic              isu_sc_valid_o,
  input  logic              isu_sc_ready_i,
  output logic [CH_W-1:0]   isu_sc_channel_id_o,
  output logic [2:0]        isu_sc_opcode_o,
  output logic [6:0]        isu_sc_set_way_offset_o,
  output logic [7:0]        isu_sc_wbuffer_id_o,
  output logic [2:0]        isu_sc_xbar_rob_num_o,
  output logic              isu_sc_last_o
);

  localparam logic [2:0] OP_WRITE_BACK = 3'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [CH_W-1:0] rr_ptr, rr_ptr_n;
  logic [CH_W-1:0] g_lat, g_lat_n;

  logic            slot_v;
  logic [CH_W-1:0] slot_ch;
  logic [2:0]      slot_opcode;
  logic [6:0]      slot_swo;
  logic [7:0]      slot_wbuf;
  logic [2:0]      slot_rob;
  logic            slot_last;

  logic            load_en;
  logic            found;
  logic [CH_W-1:0] g;
  logic [CH_W-1:0] idx;
  logic [CH_W-1:0] sel;
  logic [2:0]      sel_opcode;
  logic [6:0]      sel_swo;
  logic [7:0]      sel_wbuf;
  logic [2:0]      sel_rob;
  logic            sel_all;
  logic            load;
  logic            ld_last;
  logic [6:0]      ld_swo;
  logic [NCH-1:0]  ready_c;

  // Round-robin search: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = rr_ptr + CH_W'(k);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  // While splitting, the payload keeps coming from the latched channel,
  // which must hold its request stable until acknowledged.
  always_comb begin
    sel        = (state == ST_SPLIT) ? g_lat : g;
    sel_opcode = req_opcode_i[3*sel +: 3];
    sel_swo    = req_set_way_offset_i[7*sel +: 7];
    sel_wbuf   = req_wbuffer_id_i[8*sel +: 8];
    sel_rob    = req_rob_num_i[3*sel +: 3];
    sel_all    = req_all_offset_i[sel];
  end

  always_comb begin
    load_en  = !slot_v || isu_sc_ready_i;
    state_n  = state;
    rr_ptr_n = rr_ptr;
    g_lat_n  = g_lat;
    ready_c  = '0;
    load     = 1'b0;
    ld_last  = 1'b0;
    ld_swo   = sel_swo;

    case (state)
      ST_IDLE: begin
        if (load_en && found) begin
          load = 1'b1;
          if (sel_opcode == OP_WRITE_BACK && sel_all) begin
            // Beat 0 goes out first; the requester is not acknowledged yet.
            ld_swo  = {sel_swo[6:1], 1'b0};
            ld_last = 1'b0;
            state_n = ST_SPLIT;
            g_lat_n = g;
          end else begin
            ld_last  = 1'b1;
            ready_c  = NCH'(1) << g;
            rr_ptr_n = g + CH_W'(1);
          end
        end
      end
      ST_SPLIT: begin
        if (load_en) begin
          load     = 1'b1;
          ld_swo   = {sel_swo[6:1], 1'b1};
          ld_last  = 1'b1;
          ready_c  = NCH'(1) << g_lat;
          rr_ptr_n = g_lat + CH_W'(1);
          state_n  = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (rst_i) begin
      ready_c = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      g_lat       <= '0;
      slot_v      <= 1'b0;
      slot_ch     <= '0;
      slot_opcode <= '0;
      slot_swo    <= '0;
      slot_wbuf   <= '0;
      slot_rob    <= '0;
      slot_last   <= 1'b0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      g_lat  <= g_lat_n;
      if (load) begin
        slot_v      <= 1'b1;
        slot_ch     <= sel;
        slot_opcode <= sel_opcode;
        slot_swo    <= ld_swo;
        slot_wbuf   <= sel_wbuf;
        slot_rob    <= sel_rob;
        slot_last   <= ld_last;
      end else if (load_en) begin
        slot_v <= 1'b0;
      end
    end
  end

  assign req_ready_o             = ready_c;
  assign isu_sc_valid_o          = slot_v;
  assign isu_sc_channel_id_o     = slot_ch;
  assign isu_sc_opcode_o         = slot_opcode;
  assign isu_sc_set_way_offset_o = slot_swo;
  assign isu_sc_wbuffer_id_o     = slot_wbuf;
  assign isu_sc_xbar_rob_num_o   = slot_rob;
  assign isu_sc_last_o           = slot_last;

endmodule

// File: tb/tb_isu_sc_arbiter.sv
// tb/tb_isu_sc_arbiter.sv - directed self-checking bench for isu_sc_arbiter
module tb_isu_sc_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [11:0] req_opcode = '0;
  logic [27:0] req_swo = '0;
  logic [3:0]  req_all = '0;
  logic [31:0] req_wbuf = '0;
  logic [11:0] req_rob = '0;
  logic        sc_valid;
  logic        sc_ready = 1'b0;
  logic [1:0]  sc_ch;
  logic [2:0]  sc_opcode;
  logic [6:0]  sc_swo;
  logic [7:0]  sc_wbuf;
  logic [2:0]  sc_rob;
  logic        sc_last;

  int n_cmp = 0;
  int n_err = 0;

  wire [24:0] slot_obs = {sc_valid, sc_ch, sc_opcode, sc_swo, sc_wbuf, sc_rob, sc_last};

  isu_sc_arbiter #(.NCH(4), .CH_W(2)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .req_valid_i             (req_valid),
    .req_ready_o             (req_ready),
    .req_opcode_i            (req_opcode),
    .req_set_way_offset_i    (req_swo),
    .req_all_offset_i        (req_all),
    .req_wbuffer_id_i        (req_wbuf),
    .req_rob_num_i           (req_rob),
    .isu_sc_valid_o          (sc_valid),
    .isu_sc_ready_i          (sc_ready),
    .isu_sc_channel_id_o     (sc_ch),
    .isu_sc_opcode_o         (sc_opcode),
    .isu_sc_set_way_offset_o (sc_swo),
    .isu_sc_wbuffer_id_o     (sc_wbuf),
    .isu_sc_xbar_rob_num_o   (sc_rob),
    .isu_sc_last_o           (sc_last)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] exp_slot(input logic v, input logic [1:0] c,
                                           input logic [2:0] o, input logic [6:0] a,
                                           input logic [7:0] w, input logic [2:0] r,
                                           input logic l);
    return {v, c, o, a, w, r, l};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [2:0] op, input logic [6:0] a,
                         input logic al, input logic [7:0] w, input logic [2:0] r);
    req_valid[ch]         = 1'b1;
    req_opcode[3*ch +: 3] = op;
    req_swo[7*ch +: 7]    = a;
    req_all[ch]           = al;
    req_wbuf[8*ch +: 8]   = w;
    req_rob[3*ch +: 3]    = r;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    req_all   = '0;
    tick();
    rst = 1'b0;
  endtask

  // Channel c in the fairness tests carries swo 0x20+2c, wbuf 0xA0+c, rob c.
  task automatic load_all_reads;
    for (int c = 0; c < 4; c++) set_req(c, 3'd1, 7'(32 + 2*c), 1'b0, 8'(160 + c), 3'(c));
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    sc_ready = 1'b1;
    load_all_reads();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_err++; $display("FAIL reset_ready[%0d]: got %b want 0000", i, req_ready);
      end
      tick();
      n_cmp++;
      if (slot_obs !== 25'd0) begin
        n_err++; $display("FAIL reset_slot[%0d]: got %h want 0", i, slot_obs);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL first_grant_ready: got %b want 0001", req_ready);
    end
    tick();
    n_cmp++;
    if (slot_obs !== exp_slot(1, 0, 1, 7'h20, 8'hA0, 3'd0, 1)) begin
      n_err++; $display("FAIL first_grant_slot: got %h want %h", slot_obs,
                        exp_slot(1, 0, 1, 7'h20, 8'hA0, 3'd0, 1));
    end
  endtask

  task automatic test_round_robin;
    logic [24:0] e;
    do_reset();
    sc_ready = 1'b1;
    load_all_reads();
    for (int i = 0; i < 8; i++) begin
      tick();
      e = exp_slot(1, 2'(i % 4), 3'd1, 7'(32 + 2*(i % 4)), 8'(160 + i % 4), 3'(i % 4), 1);
      n_cmp++;
      if (slot_obs !== e) begin
        n_err++; $display("FAIL rr_seq[%0d]: got %h want %h", i, slot_obs, e);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    logic [24:0] e;
    do_reset();
    sc_ready = 1'b0;
    set_req(2, 3'd1, 7'h15, 1'b0, 8'h33, 3'd5);
    e = exp_slot(1, 2, 1, 7'h15, 8'h33, 3'd5, 1);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_load_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL bp_ready_after_load: got %b want 0000", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (slot_obs !== e) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", i, slot_obs, e);
      end
      tick();
    end
    n_cmp++;
    if (slot_obs !== e) begin
      n_err++; $display("FAIL bp_hold_end: got %h want %h", slot_obs, e);
    end
    sc_ready = 1'b1;
    tick();
    n_cmp++;
    if (sc_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain: got %b want 0", sc_valid);
    end
  endtask

  task automatic test_split(input int stall);
    logic [24:0] b0, b1, r3;
    b0 = exp_slot(1, 1, 3, 7'h2A, 8'h44, 3'd2, 0);
    b1 = exp_slot(1, 1, 3, 7'h2B, 8'h44, 3'd2, 1);
    r3 = exp_slot(1, 3, 1, 7'h10, 8'h55, 3'd6, 1);
    do_reset();
    sc_ready = (stall == 0);
    set_req(1, 3'd3, 7'h2B, 1'b1, 8'h44, 3'd2);
    set_req(3, 3'd1, 7'h10, 1'b0, 8'h55, 3'd6);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL split%0d_beat0_ready: got %b want 0000", stall, req_ready);
    end
    tick();
    n_cmp++;
    if (slot_obs !== b0) begin
      n_err++; $display("FAIL split%0d_beat0: got %h want %h", stall, slot_obs, b0);
    end
    for (int i = 0; i < stall; i++) begin
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_err++; $display("FAIL split_stall_ready[%0d]: got %b want 0000", i, req_ready);
      end
      tick();
      n_cmp++;
      if (slot_obs !== b0) begin
        n_err++; $display("FAIL split_stall_hold[%0d]: got %h want %h", i, slot_obs, b0);
      end
    end
    sc_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL split%0d_beat1_ready: got %b want 0010", stall, req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    n_cmp++;
    if (slot_obs !== b1) begin
      n_err++; $display("FAIL split%0d_beat1: got %h want %h", stall, slot_obs, b1);
    end
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_err++; $display("FAIL split%0d_ch3_ready: got %b want 1000", stall, req_ready);
    end
    tick();
    req_valid[3] = 1'b0;
    n_cmp++;
    if (slot_obs !== r3) begin
      n_err++; $display("FAIL split%0d_ch3: got %h want %h", stall, slot_obs, r3);
    end
  endtask

  task automatic test_reset_mid_split;
    logic [24:0] e;
    do_reset();
    sc_ready = 1'b0;
    set_req(1, 3'd3, 7'h2B, 1'b1, 8'h44, 3'd2);
    set_req(3, 3'd1, 7'h10, 1'b0, 8'h55, 3'd6);
    tick();
    n_cmp++;
    if (slot_obs !== exp_slot(1, 1, 3, 7'h2A, 8'h44, 3'd2, 0)) begin
      n_err++; $display("FAIL rms_beat0: got %h want %h", slot_obs,
                        exp_slot(1, 1, 3, 7'h2A, 8'h44, 3'd2, 0));
    end
    rst      = 1'b1;
    sc_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL rms_ready_in_reset: got %b want 0000", req_ready);
    end
    tick();
    n_cmp++;
    if (slot_obs !== 25'd0) begin
      n_err++; $display("FAIL rms_slot_reset: got %h want 0", slot_obs);
    end
    rst = 1'b0;
    set_req(0, 3'd1, 7'h06, 1'b0, 8'h11, 3'd1);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rms_next_ready: got %b want 0001", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    e = exp_slot(1, 0, 1, 7'h06, 8'h11, 3'd1, 1);
    n_cmp++;
    if (slot_obs !== e) begin
      n_err++; $display("FAIL rms_next_grant: got %h want %h", slot_obs, e);
    end
    tick();
    req_valid[3] = 1'b0;
    e = exp_slot(1, 3, 1, 7'h10, 8'h55, 3'd6, 1);
    n_cmp++;
    if (slot_obs !== e) begin
      n_err++; $display("FAIL rms_no_beat1: got %h want %h", slot_obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_split(0);
    test_split(2);
    test_reset_mid_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/isu_sc_arbiter.md
# isu_sc_arbiter

Round-robin scheduler in front of `sram_controller` that shares its single ISU request port among `NCH` requester channels. Each cycle it picks one eligible channel and places the request in a one-entry output register driving the `isu_sc_*` port. The block also splits a whole-line write-back request into two per-offset beats (offset 0, then offset 1) before it releases the request. It sits between the per-channel issue queues and `sram_controller`.

## Interface
- `NCH`, 4, number of requester channels; must equal 2**`CH_W`.
- `CH_W`, 2, channel-id width.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NCH  per-channel request valid.
- `req_ready_o`  out  NCH  per-channel accept; one-hot or zero.
- `req_opcode_i`  in  3*NCH  per-channel opcode: 0 WRITE, 1 READ, 2 READ_WITH_LINEFILL, 3 WRITE_BACK.
- `req_set_way_offset_i`  in  7*NCH  per-channel {set_way[5:0], offset}.
- `req_all_offset_i`  in  NCH  per-channel flag; for WRITE_BACK, write back both offsets.
- `req_wbuffer_id_i`  in  8*NCH  per-channel write-buffer id.
- `req_rob_num_i`  in  3*NCH  per-channel xbar ROB number.
- `isu_sc_valid_o`  out  1  slot valid to `sram_controller`.
- `isu_sc_ready_i`  in  1  `sram_controller` accept.
- `isu_sc_channel_id_o`  out  CH_W  granted channel index.
- `isu_sc_opcode_o`  out  3  opcode of the slot.
- `isu_sc_set_way_offset_o`  out  7  address of the slot; bit 0 is the beat offset when a request is split.
- `isu_sc_wbuffer_id_o`  out  8  write-buffer id of the slot.
- `isu_sc_xbar_rob_num_o`  out  3  ROB number of the slot.
- `isu_sc_last_o`  out  1  slot holds the final beat of its request.

## Operation
- **Slot register.** Holds `slot_v` plus the payload. `load_en = !slot_v | isu_sc_ready_i`.
- **Arbitration (state IDLE).**
  - Runs only when `load_en` is high.
  - Search starts at `rr_ptr` and goes up modulo NCH; the first `i` with `req_valid_i[i]` wins and becomes grant `g`.
  - The payload of channel `g` loads into the slot, `slot_v`<=1, and `isu_sc_channel_id_o` = g.
- **Split condition.** `split = opcode==3 & req_all_offset_i[g]`.
- **IDLE with no split.**
  - `req_ready_o[g]`=1 in the load cycle.
  - `rr_ptr` <= (g+1) mod NCH.
  - `isu_sc_last_o`=1.
- **IDLE with split.**
  - Beat 0 loads with `set_way_offset` = {set_way, 0} and `isu_sc_last_o`=0.
  - The block latches `g`, moves to state SPLIT, and does not assert `req_ready_o`.
- **SPLIT.**
  - Arbitration is frozen and the requester must hold its request stable.
  - On the next `load_en`, beat 1 loads with {set_way, 1} and `isu_sc_last_o`=1.
  - In that cycle `req_ready_o[g]`=1, `rr_ptr` <= g+1, and the block returns to IDLE.
- **Drain.** If `load_en` is high and nothing loads, `slot_v`<=0.
- **`req_ready_o`.** Combinational from the registered state and the inputs. At most one bit is high. It is 0 while `rst_i` is high.
- **Other opcodes.** The block passes opcodes 0-2 and WRITE_BACK without `all_offset` through unchanged. It does not decode illegal opcodes 4-7; these pass through.

## Timing
- **Reset values.**
  - `slot_v`=0, so `isu_sc_valid_o`=0.
  - All `isu_sc_*` payload outputs=0, `isu_sc_last_o`=0.
  - `rr_ptr`=0, state IDLE, `req_ready_o`=0.
- **Reset during SPLIT.** Abandons the split. Beat 1 is not issued and the requester was not acknowledged.
- **Latency.** With the slot empty, a request valid in cycle N appears on `isu_sc_valid_o` in cycle N+1.
- **Throughput.** One beat per cycle when `isu_sc_ready_i` is held high; back-to-back loads occur on the same edge the slot drains. A split request takes 2 beat cycles.
- **Valid/ready rules.** `isu_sc_valid_o` and the payload are stable while valid & !ready. Input requesters must not retract valid or change payload before `req_ready_o`.
- **Simultaneous requests.** Winner is the first valid at or after `rr_ptr`. A channel whose request was just granted is last priority in the next cycle.
- **Pointer wrap.** `rr_ptr` wraps NCH-1 -> 0.

## Test plan
- **Reset check.**
  - Stimulus: hold `rst_i` 2 cycles with all `req_valid_i`=4'hF.
  - Required: `req_ready_o`=0 and `isu_sc_valid_o`=0 throughout. The first grant after reset is channel 0, on `isu_sc_valid_o` one cycle later.
- **Round-robin fairness.**
  - Stimulus: `req_valid_i`=4'hF, `isu_sc_ready_i`=1, 8 cycles.
  - Required: `isu_sc_channel_id_o` sequence 0,1,2,3,0,1,2,3 with `isu_sc_valid_o` high every cycle.
- **Backpressure.**
  - Stimulus: single READ on ch2 (set_way_offset 7'h15, rob 5), `isu_sc_ready_i`=0 for 3 cycles.
  - Required: slot holds ch2/opcode 1/7'h15/rob 5 stable. `req_ready_o` pulses only in the load cycle. The slot drains on the cycle ready rises.
- **Write-back split.**
  - Stimulus: ch1 WRITE_BACK, `all_offset`=1, set_way_offset 7'h2B; ch3 READ valid at the same time; ready=1.
  - Required, cycle by cycle:
    - beat 7'h2A with last=0;
    - beat 7'h2B with last=1;
    - `req_ready_o[1]`=1 only on the second beat, and ch3 is not granted until the cycle after beat 1 loads (its READ appears the cycle after beat 1 is on the output).
- **Split under stall.**
  - Stimulus: same as the previous test, with ready=0 while beat 0 is in the slot.
  - Required: beat 0 is held, no other channel is granted, and beat 1 follows after ready.
- **Reset mid-split.**
  - Stimulus: assert `rst_i` in SPLIT.
  - Required: outputs return to reset values, the next grant comes from channel 0, and no beat 1 is emitted.
